// File: rtl/debug_uart_dump_if.sv
// rtl/debug_uart_dump_if.sv - debug-port and UART signal bundle for the register-dump serializer
interface debug_uart_dump_if;
  logic        start;
  logic [31:0] PC;
  logic [31:0] debug_reg_out;
  logic [4:0]  debug_reg_select;
  logic        tx;
  logic        busy;
  logic        done;

  // master: the side that requests dumps and supplies PC / register data
  modport master (
    output start, PC, debug_reg_out,
    input  debug_reg_select, tx, busy, done
  );

  // slave: the serializer itself
  modport slave (
    input  start, PC, debug_reg_out,
    output debug_reg_select, tx, busy, done
  );
endinterface

// File: rtl/debug_uart_dump.sv
// rtl/debug_uart_dump.sv - dumps PC and x0..x31 as uppercase hex lines over an 8N1 UART
module debug_uart_dump #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             reset,
  debug_uart_dump_if.slave bus
);
  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LATCH,
    START_BIT,
    DATA,
    STOP_BIT,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      word;      // value being sent on the current line
  logic [3:0]       char_idx;  // 0..7 hex digits, 8 = CR, 9 = LF
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] clk_cnt;
  logic             pc_line;   // current line carries PC rather than a register
  logic [3:0]       nibble;
  logic [7:0]       cur_char;

  // ASCII character for the current position in the line
  always_comb begin
    nibble = word[31:28];
    case (char_idx[2:0])
      3'd0:    nibble = word[31:28];
      3'd1:    nibble = word[27:24];
      3'd2:    nibble = word[23:20];
      3'd3:    nibble = word[19:16];
      3'd4:    nibble = word[15:12];
      3'd5:    nibble = word[11:8];
      3'd6:    nibble = word[7:4];
      default: nibble = word[3:0];
    endcase
    if (char_idx == 4'd8) begin
      cur_char = 8'h0D;
    end else if (char_idx == 4'd9) begin
      cur_char = 8'h0A;
    end else if (nibble < 4'd10) begin
      cur_char = 8'h30 + {4'h0, nibble};
    end else begin
      cur_char = 8'h37 + {4'h0, nibble};
    end
  end

  // dump sequencer and UART transmitter; tx/busy/done/select are all registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= IDLE;
      word                 <= '0;
      char_idx             <= '0;
      bit_idx              <= '0;
      clk_cnt              <= '0;
      pc_line              <= 1'b0;
      bus.tx               <= 1'b1;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.debug_reg_select <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            word     <= bus.PC;
            pc_line  <= 1'b1;
            char_idx <= '0;
            clk_cnt  <= '0;
            bus.busy <= 1'b1;
            bus.tx   <= 1'b0;
            state    <= START_BIT;
          end
        end
        SELECT: begin
          state <= LATCH;
        end
        LATCH: begin
          word   <= bus.debug_reg_out;
          bus.tx <= 1'b0;
          state  <= START_BIT;
        end
        START_BIT: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            bus.tx  <= cur_char[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bus.tx <= 1'b1;
              state  <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              bus.tx  <= cur_char[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP_BIT: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (char_idx != 4'd9) begin
              char_idx <= char_idx + 4'd1;
              bus.tx   <= 1'b0;
              state    <= START_BIT;
            end else begin
              char_idx <= '0;
              if (pc_line) begin
                pc_line              <= 1'b0;
                bus.debug_reg_select <= '0;
                state                <= SELECT;
              end else if (bus.debug_reg_select == 5'd31) begin
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                state    <= DONE;
              end else begin
                bus.debug_reg_select <= bus.debug_reg_select + 5'd1;
                state                <= SELECT;
              end
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_debug_uart_dump.sv
// tb/tb_debug_uart_dump.sv - scoreboard bench for debug_uart_dump
module tb_debug_uart_dump;
  localparam int C      = 4;
  localparam int DUMP_T = 330 * 10 * C + 64;

  logic clk = 1'b0;
  logic reset;

  debug_uart_dump_if bus ();

  debug_uart_dump #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] regs [32];
  logic        override;
  logic [7:0]  sb [$];
  int          cyc = 0;

  logic       dec_active;
  int         dec_cnt;
  logic [7:0] dec_shift;
  logic       dec_start_ok;
  logic       rx_valid;
  logic [7:0] rx_char;
  logic       rx_frame_ok;
  logic       start_seen;
  int         start_cyc;
  logic [4:0] sel_now, sel_prev1, sel_prev2;

  int done_t, busy_fall_t, done_pulses, rx_n, start_n;

  // register-file model seen by the dumper; override models the register changing mid-line
  always_comb bus.debug_reg_out = override ? 32'h12345678 : regs[bus.debug_reg_select];

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_line(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) sb.push_back(hex_char(w[i*4 +: 4]));
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
  endtask

  // advance one clock, sample 1 time unit after the edge and run the UART decoder
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rx_valid   = 1'b0;
    start_seen = 1'b0;
    if (!dec_active) begin
      if (bus.tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
        start_seen = 1'b1;
        start_cyc  = cyc;
      end
    end else begin
      dec_cnt++;
    end
    if (dec_active) begin
      if (dec_cnt == C / 2) dec_start_ok = (bus.tx === 1'b0);
      for (int i = 0; i < 8; i++)
        if (dec_cnt == C * (i + 1) + C / 2) dec_shift[i] = bus.tx;
      if (dec_cnt == 9 * C + C / 2) begin
        rx_valid    = 1'b1;
        rx_char     = dec_shift;
        rx_frame_ok = dec_start_ok && (bus.tx === 1'b1);
        dec_active  = 1'b0;
      end
    end
    sel_prev2 = sel_prev1;
    sel_prev1 = sel_now;
    sel_now   = bus.debug_reg_select;
  endtask

  // start a dump, push its expected characters, decode and compare until done (or stop_char)
  task automatic run_dump(input logic [31:0] pc, input bit features, input int stop_char,
                          input int tail, input bit hold);
    int         t;
    int         e0;
    int         last_start;
    int         gap;
    int         exp_gap;
    logic [7:0] exp_c;
    logic [7:0] first_c;
    logic       exp_tx;
    sb.delete();
    push_line(pc);
    for (int k = 0; k < 32; k++) push_line(regs[k]);
    first_c     = hex_char(pc[31:28]);
    rx_n        = 0;
    start_n     = 0;
    done_t      = -1;
    busy_fall_t = -1;
    done_pulses = 0;
    dec_active  = 1'b0;
    last_start  = 0;
    bus.PC      = pc;
    bus.start   = 1'b1;
    e0          = cyc + 1;
    while (1) begin
      tick();
      t = cyc - e0;
      if (t == 0) begin
        if (!hold) bus.start = 1'b0;
        bus.PC = ~pc;
        checks++;
        if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
          failures++;
          $display("FAIL start_latency busy=%b tx=%b expected busy=1 tx=0", bus.busy, bus.tx);
        end
      end
      if (features && t < 10 * C) begin
        exp_tx = (t < C) ? 1'b0 : (t < 9 * C) ? first_c[(t - C) / C] : 1'b1;
        checks++;
        if (bus.tx !== exp_tx) begin
          failures++;
          $display("FAIL pc_char0_wave t=%0d tx=%b expected %b", t, bus.tx, exp_tx);
        end
      end
      if (features && t == 500) bus.start = 1'b1;
      if (features && t == 501) bus.start = 1'b0;
      if (start_seen) begin
        if (start_n > 0) begin
          gap     = start_cyc - last_start - 10 * C;
          exp_gap = (start_n % 10 == 0) ? 2 : 0;
          checks++;
          if (gap != exp_gap) begin
            failures++;
            $display("FAIL char_gap char=%0d gap=%0d expected %0d", start_n, gap, exp_gap);
          end
        end
        if (features && start_n == 60) begin
          checks++;
          if (sel_prev1 !== 5'd5 || sel_prev2 !== 5'd5) begin
            failures++;
            $display("FAIL select_x5 select=%0d,%0d expected 5,5", sel_prev2, sel_prev1);
          end
        end
        if (features && start_n == 62) override = 1'b1;
        if (features && start_n == 65) override = 1'b0;
        last_start = start_cyc;
        if (start_n == stop_char) return;
        start_n++;
      end
      if (rx_valid) begin
        rx_n++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL extra_char got=%02h expected none", rx_char);
        end else begin
          exp_c = sb.pop_front();
          if (rx_char !== exp_c || !rx_frame_ok) begin
            failures++;
            $display("FAIL rx_char idx=%0d got=%02h frame=%b expected %02h frame=1",
                     rx_n - 1, rx_char, rx_frame_ok, exp_c);
          end
        end
      end
      if (bus.done === 1'b1) begin
        done_pulses++;
        if (done_t < 0) done_t = t;
      end
      if (busy_fall_t < 0 && bus.busy !== 1'b1) busy_fall_t = t;
      if (done_t >= 0 && t >= done_t + tail) break;
      if (t > DUMP_T + 200) begin
        checks++;
        failures++;
        $display("FAIL dump_timeout t=%0d expected done by %0d", t, DUMP_T);
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.start = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.debug_reg_select !== 5'd0) begin
        failures++;
        $display("FAIL reset_state tx=%b busy=%b done=%b sel=%0d expected 1 0 0 0",
                 bus.tx, bus.busy, bus.done, bus.debug_reg_select);
      end
    end
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (4) begin
      tick();
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle tx=%b busy=%b expected tx=1 busy=0", bus.tx, bus.busy);
      end
    end
  endtask

  task automatic test_full_dump();
    run_dump(32'h004000AC, 1'b1, -1, 8, 1'b0);
    checks++;
    if (done_t != DUMP_T) begin
      failures++;
      $display("FAIL done_time got=%0d expected %0d", done_t, DUMP_T);
    end
    checks++;
    if (busy_fall_t != DUMP_T) begin
      failures++;
      $display("FAIL busy_fall got=%0d expected %0d", busy_fall_t, DUMP_T);
    end
    checks++;
    if (done_pulses != 1) begin
      failures++;
      $display("FAIL done_pulse_width got=%0d expected 1", done_pulses);
    end
    checks++;
    if (rx_n != 330 || sb.size() != 0) begin
      failures++;
      $display("FAIL char_count got=%0d left=%0d expected 330 left=0", rx_n, sb.size());
    end
    checks++;
    if (bus.debug_reg_select !== 5'd31 || bus.tx !== 1'b1) begin
      failures++;
      $display("FAIL post_dump sel=%0d tx=%b expected sel=31 tx=1", bus.debug_reg_select, bus.tx);
    end
  endtask

  task automatic test_reset_mid();
    run_dump(32'hCAFE0010, 1'b0, 92, 0, 1'b0);
    checks++;
    if (start_n != 92) begin
      failures++;
      $display("FAIL mid_reached chars=%0d expected 92", start_n);
    end
    repeat (C + 1) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.debug_reg_select !== 5'd0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset tx=%b busy=%b sel=%0d done=%b expected 1 0 0 0",
               bus.tx, bus.busy, bus.debug_reg_select, bus.done);
    end
    reset      = 1'b1;
    dec_active = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_idle tx=%b busy=%b expected tx=1 busy=0", bus.tx, bus.busy);
      end
    end
  endtask

  task automatic test_restart();
    run_dump(32'h3C5AF00D, 1'b0, -1, 4, 1'b0);
    checks++;
    if (done_t != DUMP_T || rx_n != 330 || sb.size() != 0) begin
      failures++;
      $display("FAIL restart_dump done_t=%0d chars=%0d left=%0d expected %0d 330 0",
               done_t, rx_n, sb.size(), DUMP_T);
    end
  endtask

  task automatic test_back_to_back();
    run_dump(32'h00000F0F, 1'b0, -1, 0, 1'b1);
    checks++;
    if (done_t != DUMP_T || rx_n != 330) begin
      failures++;
      $display("FAIL held_start_dump done_t=%0d chars=%0d expected %0d 330", done_t, rx_n, DUMP_T);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle busy=%b tx=%b done=%b expected 0 1 0", bus.busy, bus.tx, bus.done);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
      failures++;
      $display("FAIL b2b_retrigger busy=%b tx=%b expected busy=1 tx=0", bus.busy, bus.tx);
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 32; k++) regs[k] = 32'h9E3779B9 * 32'(k);
    regs[0]    = 32'h00000000;
    regs[5]    = 32'hDEADBEEF;
    override   = 1'b0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.PC     = '0;
    dec_active = 1'b0;
    dec_cnt    = 0;
    dec_shift  = '0;
    dec_start_ok = 1'b0;
    sel_now    = '0;
    sel_prev1  = '0;
    sel_prev2  = '0;
    test_reset();
    test_full_dump();
    test_reset_mid();
    test_restart();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
